// File: rtl/vending_controller.sv
// vending_controller: multi-product coin vending FSM with credit ceiling, cancel/refund and pulsed change payout
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   coin_valid/type   one-cycle coin strobe and index into COIN_VALUES
//   sel_valid/sel_id  one-cycle product select strobe and product index
//   cancel            one-cycle refund request
//   credit            current credit
//   busy              high while vending or paying out change
//   vend_valid/id     one-cycle dispense pulse and the product dispensed
//   change_pulse      one CHANGE_UNIT paid out this cycle
//   coin_reject       coin returned to the customer
//   sel_short         selection refused (too little credit or no such product)
module vending_controller #(
  parameter int CREDIT_W = 8,
  parameter int N_PRODUCTS = 4,
  parameter int SEL_W = 2,
  parameter logic [4*CREDIT_W-1:0] COIN_VALUES = {8'd50, 8'd20, 8'd10, 8'd5},
  parameter logic [N_PRODUCTS*CREDIT_W-1:0] PRICES = {8'd40, 8'd25, 8'd20, 8'd15},
  parameter int MAX_CREDIT = 100,
  parameter int CHANGE_UNIT = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_id,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                sel_short
);
  localparam logic [CREDIT_W-1:0] UNIT = CREDIT_W'(CHANGE_UNIT);
  localparam logic [CREDIT_W:0] MAX = (CREDIT_W+1)'(MAX_CREDIT);
  typedef enum logic [1:0] {S_ACCEPT, S_VEND, S_REFUND} state_t;
  state_t r_state, w_state;
  logic [CREDIT_W-1:0] r_credit, w_credit;
  logic [SEL_W-1:0] r_vend_id, w_vend_id;
  logic r_busy, r_vend_valid, w_vend_valid, r_change, w_change, r_reject, w_reject, r_short, w_short;
  logic [CREDIT_W-1:0] w_coins [4];
  logic [CREDIT_W-1:0] w_prices [2**SEL_W];
  logic [CREDIT_W-1:0] w_price, w_dec;
  logic [CREDIT_W:0] w_sum;
  logic w_sel_ok;
  for (genvar g = 0; g < 4; g++) begin : g_coin
    assign w_coins[g] = COIN_VALUES[g*CREDIT_W +: CREDIT_W];
  end
  // Unused select codes get price 0; they are refused by the index check anyway.
  for (genvar g = 0; g < 2**SEL_W; g++) begin : g_price
    if (g < N_PRODUCTS) begin : g_real
      assign w_prices[g] = PRICES[g*CREDIT_W +: CREDIT_W];
    end else begin : g_none
      assign w_prices[g] = '0;
    end
  end
  assign w_price = w_prices[sel_id];
  assign w_sel_ok = (32'(sel_id) < N_PRODUCTS) && (r_credit >= w_price);
  assign w_sum = {1'b0, r_credit} + {1'b0, w_coins[coin_type]};
  assign w_dec = (r_credit <= UNIT) ? '0 : r_credit - UNIT;
  // Pulses are decided one cycle ahead so that change_pulse and the reduced
  // credit appear together; REFUND exits on the cycle after credit reaches 0.
  always_comb begin
    w_state = r_state;
    w_credit = r_credit;
    w_vend_id = r_vend_id;
    w_vend_valid = 1'b0;
    w_change = 1'b0;
    w_reject = 1'b0;
    w_short = 1'b0;
    case (r_state)
      S_ACCEPT: begin
        if (cancel && r_credit != '0) begin
          w_state = S_REFUND;
          w_change = 1'b1;
          w_credit = w_dec;
          w_reject = coin_valid;
        end else if (sel_valid) begin
          w_reject = coin_valid;
          w_short = !w_sel_ok;
          if (w_sel_ok) begin
            w_state = S_VEND;
            w_vend_valid = 1'b1;
            w_vend_id = sel_id;
            w_credit = r_credit - w_price;
          end
        end else if (coin_valid) begin
          w_reject = w_sum > MAX;
          w_credit = (w_sum > MAX) ? r_credit : w_sum[CREDIT_W-1:0];
        end
      end
      default: begin
        w_reject = coin_valid;
        w_change = r_credit != '0;
        w_credit = w_dec;
        w_state = (r_credit != '0) ? S_REFUND : S_ACCEPT;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_ACCEPT;
      r_credit <= '0;
      r_vend_id <= '0;
      r_busy <= 1'b0;
      r_vend_valid <= 1'b0;
      r_change <= 1'b0;
      r_reject <= 1'b0;
      r_short <= 1'b0;
    end else begin
      r_state <= w_state;
      r_credit <= w_credit;
      r_vend_id <= w_vend_id;
      r_busy <= w_state != S_ACCEPT;
      r_vend_valid <= w_vend_valid;
      r_change <= w_change;
      r_reject <= w_reject;
      r_short <= w_short;
    end
  end
  assign credit = r_credit;
  assign busy = r_busy;
  assign vend_valid = r_vend_valid;
  assign vend_id = r_vend_id;
  assign change_pulse = r_change;
  assign coin_reject = r_reject;
  assign sel_short = r_short;
endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller: vector table and scoreboard bench for vending_controller
module tb_vending_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0;
  logic [1:0] coin_type = '0, sel_id = '0;
  logic [7:0] credit;
  logic busy, vend_valid, change_pulse, coin_reject, sel_short;
  logic [1:0] vend_id;
  logic c3_valid = 1'b0, s3_valid = 1'b0, x3_cancel = 1'b0;
  logic [1:0] c3_type = '0, s3_id = '0;
  logic [7:0] credit3;
  logic busy3, vv3, cp3, cr3, ss3;
  logic [1:0] vid3;
  int checks = 0, fails = 0;
  typedef struct {
    logic cv; logic [1:0] ct; logic sv; logic [1:0] sid; logic cn;
    int cr; logic b; logic vv; logic [1:0] vid; logic cp; logic rj; logic ss;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  int idx = 0;
  always #5 clk = ~clk;
  vending_controller dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .credit(credit),
    .busy(busy), .vend_valid(vend_valid), .vend_id(vend_id), .change_pulse(change_pulse),
    .coin_reject(coin_reject), .sel_short(sel_short)
  );
  vending_controller #(.N_PRODUCTS(3), .PRICES({8'd25, 8'd20, 8'd15})) dut3 (
    .clk(clk), .reset(reset), .coin_valid(c3_valid), .coin_type(c3_type),
    .sel_valid(s3_valid), .sel_id(s3_id), .cancel(x3_cancel), .credit(credit3),
    .busy(busy3), .vend_valid(vv3), .vend_id(vid3), .change_pulse(cp3),
    .coin_reject(cr3), .sel_short(ss3)
  );
  function automatic vec_t mk(logic cv, logic [1:0] ct, logic sv, logic [1:0] sid, logic cn,
                              int cr, logic b, logic vv, logic [1:0] vid, logic cp, logic rj, logic ss);
    vec_t v;
    v.cv = cv; v.ct = ct; v.sv = sv; v.sid = sid; v.cn = cn;
    v.cr = cr; v.b = b; v.vv = vv; v.vid = vid; v.cp = cp; v.rj = rj; v.ss = ss;
    return v;
  endfunction
  task automatic chk(input string n, input int a, input int x);
    checks++;
    if (a != x) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, x);
    end
  endtask
  task automatic step(input vec_t v);
    vec_t e;
    coin_valid = v.cv; coin_type = v.ct; sel_valid = v.sv; sel_id = v.sid; cancel = v.cn;
    sb.push_back(v);
    @(posedge clk);
    #1;
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
    if (sb.size() == 0) begin
      chk($sformatf("v%0d scoreboard_empty", idx), 1, 0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d credit", idx), int'(credit), e.cr);
      chk($sformatf("v%0d busy", idx), int'(busy), int'(e.b));
      chk($sformatf("v%0d vend_valid", idx), int'(vend_valid), int'(e.vv));
      chk($sformatf("v%0d vend_id", idx), int'(vend_id), int'(e.vid));
      chk($sformatf("v%0d change_pulse", idx), int'(change_pulse), int'(e.cp));
      chk($sformatf("v%0d coin_reject", idx), int'(coin_reject), int'(e.rj));
      chk($sformatf("v%0d sel_short", idx), int'(sel_short), int'(e.ss));
    end
    idx++;
  endtask
  task automatic step3(input logic cv, input logic [1:0] ct, input logic sv, input logic [1:0] sid,
                       input int cr, input logic vv, input logic ss);
    c3_valid = cv; c3_type = ct; s3_valid = sv; s3_id = sid;
    @(posedge clk);
    #1;
    c3_valid = 1'b0; s3_valid = 1'b0;
    chk($sformatf("n3 v%0d credit", idx), int'(credit3), cr);
    chk($sformatf("n3 v%0d vend_valid", idx), int'(vv3), int'(vv));
    chk($sformatf("n3 v%0d sel_short", idx), int'(ss3), int'(ss));
    idx++;
  endtask
  initial begin
    // coin 5, coin 10, exact-price vend of product 0
    tbl.push_back(mk(1, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // coin 50, vend product 2, five change pulses
    tbl.push_back(mk(1, 3, 0, 0, 0, 50, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 25, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 20, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 15, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 10, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  5, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0));
    // insufficient credit, then cancel refunds 10
    tbl.push_back(mk(1, 1, 0, 0, 0, 10, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 0, 10, 0, 0, 2, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 10, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1,  5, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0));
    // cancel with zero credit does nothing
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 2, 0, 0, 0));
    // fill to 90, overflowing coin rejected
    tbl.push_back(mk(1, 3, 0, 0, 0, 50, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 70, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 90, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 90, 0, 0, 2, 0, 1, 0));
    #1;
    chk("reset credit", int'(credit), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset vend_id", int'(vend_id), 0);
    chk("reset pulses", int'({vend_valid, change_pulse, coin_reject, sel_short}), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    // cancel at 90 pays 18 pulses
    step(mk(0, 0, 0, 0, 1, 85, 1, 0, 2, 1, 0, 0));
    for (int i = 1; i < 18; i++) step(mk(0, 0, 0, 0, 0, 85 - 5 * i, 1, 0, 2, 1, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    // select plus coin in one cycle, then a coin during payout
    step(mk(1, 2, 0, 0, 0, 20, 0, 0, 2, 0, 0, 0));
    step(mk(1, 2, 1, 0, 0,  5, 1, 1, 0, 0, 1, 0));
    step(mk(1, 2, 0, 0, 0,  0, 1, 0, 0, 1, 1, 0));
    step(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // credit ceiling reached exactly, then one more coin refused
    step(mk(1, 3, 0, 0, 0,  50, 0, 0, 0, 0, 0, 0));
    step(mk(1, 3, 0, 0, 0, 100, 0, 0, 0, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 100, 0, 0, 0, 0, 1, 0));
    step(mk(0, 0, 1, 3, 0,  60, 1, 1, 3, 0, 0, 0));
    for (int i = 1; i <= 12; i++) step(mk(0, 0, 0, 0, 0, 60 - 5 * i, 1, 0, 3, 1, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    // reset after two of seven refund pulses
    step(mk(1, 2, 0, 0, 0, 20, 0, 0, 3, 0, 0, 0));
    step(mk(1, 1, 0, 0, 0, 30, 0, 0, 3, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 35, 0, 0, 3, 0, 0, 0));
    step(mk(0, 0, 0, 0, 1, 30, 1, 0, 3, 1, 0, 0));
    step(mk(0, 0, 0, 0, 0, 25, 1, 0, 3, 1, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    chk("async reset credit", int'(credit), 0);
    chk("async reset change_pulse", int'(change_pulse), 0);
    chk("async reset busy", int'(busy), 0);
    chk("async reset vend_id", int'(vend_id), 0);
    @(negedge clk);
    reset = 1'b0;
    step(mk(1, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
    // three-product build: index 3 does not exist
    step3(1, 1, 0, 0, 10, 0, 0);
    step3(0, 0, 1, 3, 10, 0, 1);
    step3(0, 0, 1, 0, 10, 0, 1);
    step3(1, 0, 0, 0, 15, 0, 0);
    step3(0, 0, 1, 0,  0, 1, 0);
    chk("n3 vend_id", int'(vid3), 0);
    chk("scoreboard drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/vending_controller.md
# vending_controller

Parametrised multi-product vending controller that accumulates coin credit, vends a selected product against a per-product price, and pays out remaining credit as a stream of unit-value change pulses. It generalises the fixed two-coin, single-price, single-product machine: coin values, product count, prices, credit ceiling and change unit are all parameters. It adds cancel/refund, overflow rejection and multi-cycle change payout. It sits between the coin acceptor/keypad front end and the dispenser/hopper drivers.

## Interface
- CREDIT_W, 8, width of credit and all value fields
- N_PRODUCTS, 4, number of selectable products (2..16)
- SEL_W, 2, width of sel_id; must satisfy 2**SEL_W >= N_PRODUCTS
- COIN_VALUES, {8'd50,8'd20,8'd10,8'd5}, packed 4×CREDIT_W; coin i value = COIN_VALUES[i*CREDIT_W +: CREDIT_W]
- PRICES, {8'd40,8'd25,8'd20,8'd15}, packed N_PRODUCTS×CREDIT_W; product i price at slice i
- MAX_CREDIT, 100, credit ceiling; must be < 2**CREDIT_W
- CHANGE_UNIT, 5, value of one change pulse; all coin values and prices are multiples of it
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- coin_valid  in  1  one-cycle strobe, coin inserted
- coin_type  in  2  coin index into COIN_VALUES
- sel_valid  in  1  one-cycle strobe, product selected
- sel_id  in  SEL_W  product index
- cancel  in  1  one-cycle strobe, refund request
- credit  out  CREDIT_W  current credit (registered)
- busy  out  1  high in VEND or REFUND
- vend_valid  out  1  one-cycle dispense pulse
- vend_id  out  SEL_W  product being dispensed, valid with vend_valid
- change_pulse  out  1  one change unit paid this cycle
- coin_reject  out  1  one-cycle pulse, coin returned
- sel_short  out  1  one-cycle pulse, insufficient credit or invalid sel_id

## Operation
- States: ACCEPT, VEND, REFUND. Reset → ACCEPT. credit=0, vend_id=0, all pulse outputs and busy = 0.
- ACCEPT, priority cancel > sel_valid > coin_valid. Evaluate the highest-priority active strobe only.
  - cancel, credit>0: → REFUND. cancel with credit=0: ignored.
  - sel_valid, sel_id<N_PRODUCTS, credit>=PRICES[sel_id]: credit -= price, latch vend_id, → VEND.
  - sel_valid, otherwise: pulse sel_short, credit unchanged, stay.
  - coin_valid only: if credit+value <= MAX_CREDIT, credit += value. Else pulse coin_reject, credit unchanged. Compute the sum at CREDIT_W+1 bits.
  - A coin arriving in the same cycle as an acted-on cancel or sel_valid is rejected (coin_reject pulse). This includes a sel_valid that produces sel_short.
- VEND: vend_valid=1 for exactly one cycle. Then → REFUND if credit>0, else → ACCEPT.
- REFUND: change_pulse=1 each cycle, credit -= CHANGE_UNIT. When credit <= CHANGE_UNIT, the cycle's pulse drives credit to 0 and the next state is ACCEPT.
- VEND/REFUND: coin_valid → coin_reject pulse. sel_valid and cancel are ignored (no sel_short).
- busy = (state != ACCEPT), registered with the state.

## Timing
- All outputs are registered. A strobe sampled at edge t takes effect in the outputs after edge t; call this "cycle t+1".
- Coin accept: credit updated in cycle t+1. coin_reject, when asserted, is high in cycle t+1 only.
- Successful select at t: vend_valid, vend_id and busy high in t+1. Credit already reduced in t+1.
- Change: first change_pulse in t+2 after a vend, or t+1 after a cancel. Pulses run back-to-back for N = credit/CHANGE_UNIT cycles. busy falls in the cycle after the last pulse.
- Vend with exact credit: busy for 1 cycle, no change pulses.
- Reset asserted mid-VEND/REFUND: immediately (asynchronously) forces ACCEPT, credit=0, all pulses low. Remaining change is forfeited.
- Continuous payout: no handshake with the hopper.

## Test plan
- Reset, coin 5 then coin 10, then sel_id=0 (price 15) → vend_valid one cycle, vend_id=0, credit=0, no change_pulse, busy 1 cycle.
- Coin 50, sel_id=2 (25) → credit=25 with vend_valid. Then 5 consecutive change_pulse, credit 20,15,10,5,0. Then busy=0.
- Coin 10, sel_id=3 (40) → sel_short one cycle, credit stays 10. Then sel_id=3 with sel_id=… invalid index on N_PRODUCTS=3 build → sel_short.
- Coins 50,20,20 (credit 90), then coin 20 → coin_reject, credit 90. Then cancel → 18 change_pulse, credit 0.
- Same-cycle sel_valid(id 0)+coin_valid(20) with credit 20 → vend, coin_reject, change 1 pulse. Coin during REFUND → coin_reject, credit trajectory unaffected.
- Reset asserted after 2 of 7 refund pulses → credit=0, change_pulse=0, busy=0 immediately. Next coin 5 accepted normally.
